cpu_control: RTL and testbench
==============================

Name: cpu_control

Overview:
- Instruction-side control for the 8-bit CPU: holds the PC, decodes the 32-bit instruction and drives the ALU SELECT code and operand-mux controls.
- Consumes the ALU ZERO flag to resolve beq/bne, and sequences run, stall and halt.
- Sits between instruction memory, the register file and the ALU, as the producer of SELECT and the consumer of ZERO.

Parameters:
- PC_W, 32, program-counter width in bits.
- RESET_PC, 0, PC value loaded on reset (word-aligned).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- INSTRUCTION  in  32  current instruction word.
  - [31:24] opcode.
  - [23:16] dest register, or signed branch offset in words.
  - [15:8] source 1.
  - [7:0] source 2 or immediate.
- IMEM_BUSYWAIT  in  1  instruction memory not ready; INSTRUCTION is invalid while high.
- ZERO  in  1  ALU zero flag, sampled at the rising edge.
- PC  out  PC_W  current fetch address.
- ALUOP  out  3  ALU SELECT: 000 fwd, 001 add, 010 and, 011 or, 100 ror.
- IMM_SEL  out  1  ALU DATA2 comes from the immediate.
- NEG_SEL  out  1  two's-complement DATA2 (sub, beq, bne).
- IMMEDIATE  out  8  equals INSTRUCTION[7:0].
- REG_WRITE  out  1  register-file write enable.
- WRITE_ADDR, READ1_ADDR, READ2_ADDR  out  3 each  taken from INSTRUCTION [18:16], [10:8], [2:0].
- ILLEGAL  out  1  sticky undefined-opcode flag.

Behaviour:
- Opcodes:
  - 0x00 loadi, 0x01 mov, 0x02 add, 0x03 sub, 0x04 and, 0x05 or, 0x06 j, 0x07 beq, 0x08 bne, 0x09 ror, 0xFF halt.
  - Any other opcode is illegal.
- Reset (RESET==0 at a rising edge): PC=RESET_PC, state=IDLE, ILLEGAL=0. Reset wins over every other event, including a reset asserted mid-stall or while HALT.
- Output values outside EXEC: REG_WRITE=0, ALUOP=000, IMM_SEL=0, NEG_SEL=0. The address outputs and IMMEDIATE still follow INSTRUCTION.
- States:
  - IDLE: lasts exactly one cycle after reset is released, then goes to EXEC. PC holds.
  - EXEC: outputs are decoded combinationally from INSTRUCTION.
  - HALT: PC frozen, outputs deasserted, exit only via reset.
- Decode:
  - loadi: fwd, IMM_SEL=1.
  - mov: fwd.
  - add: add.
  - sub: add with NEG_SEL=1.
  - and: and.
  - or: or.
  - ror: ror with IMM_SEL=1.
  - REG_WRITE=1 for all of the above.
  - beq/bne: add with NEG_SEL=1, REG_WRITE=0.
  - j and halt: REG_WRITE=0.
- Stall: while IMEM_BUSYWAIT=1 in EXEC, REG_WRITE is forced to 0, PC holds and ZERO is ignored. The first edge with IMEM_BUSYWAIT=0 completes the instruction.
- Next PC at the completing edge:
  - Default: PC+4.
  - j, beq when ZERO=1, bne when ZERO=0: PC+4+(sign-extended INSTRUCTION[23:16] << 2).
  - Arithmetic is modulo 2^PC_W, so PC 0xFFFFFFFC+4 gives 0.
- Latency: one cycle per instruction, plus one cycle per busy-wait cycle. The branch target appears on PC in the cycle after the completing edge.
- halt at the completing edge: PC keeps its current value and the state goes to HALT.
- Illegal opcode: executes as a NOP (PC+4, REG_WRITE=0) and sets ILLEGAL at the completing edge. ILLEGAL stays set until reset.

Optional Feature:
- Macro: CPU_CONTROL_PERF_EN.
- Defined: adds outputs RETIRED_COUNT[15:0] and TAKEN_COUNT[15:0].
  - Both are 0 on reset and saturate at 0xFFFF.
  - RETIRED_COUNT increments on each completing edge in EXEC, halt included.
  - TAKEN_COUNT increments when a branch or jump redirects PC.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode constants;
  - ALUOP codes matching the ALU SELECT encoding;
  - state encoding IDLE/EXEC/HALT.
- One sub-module, pc_unit: the PC register, the PC+4 adder and the branch-target adder, with a select and hold input.

Test Plan:
- Reset then release; loadi 0x00_02_00_05 → PC=0 during IDLE and the first EXEC cycle; ALUOP=000, IMM_SEL=1, REG_WRITE=1, WRITE_ADDR=2; PC=4 after the completing edge.
- At PC=8, beq offset 0xFE with ZERO=1 → PC=4 (8+4-8); the same instruction with ZERO=0 → PC=12; bne shows the inverse.
- IMEM_BUSYWAIT held high for 3 cycles on add → REG_WRITE=0 and PC constant for 3 cycles; REG_WRITE=1 for exactly one cycle after; PC advances by 4 once.
- Opcode 0x42 → ILLEGAL=1 and sticky, PC+4, no write; then halt → PC frozen for 10 cycles; RESET low for one edge → PC=0, ILLEGAL=0.
- PC forced to 0xFFFFFFFC via j chain, then add → PC wraps to 0x00000000.
- With CPU_CONTROL_PERF_EN defined: 5 instructions including 2 taken branches → RETIRED_COUNT=5, TAKEN_COUNT=2.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the 8-bit CPU instruction-side control:
//   - opcode constants (INSTRUCTION[31:24])
//   - ALU SELECT codes as seen by the ALU
//   - control FSM state encoding
//   - decode_op(): opcode -> control bundle, used by cpu_control
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;
  localparam logic [7:0] OP_ROR   = 8'h09;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [2:0] {
    ALU_FWD = 3'b000,
    ALU_ADD = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_ROR = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    alu_op_e aluop;
    logic    imm_sel;
    logic    neg_sel;
    logic    reg_write;
    logic    legal;
    logic    is_halt;
    logic    is_jump;
    logic    is_beq;
    logic    is_bne;
  } decode_t;

  // Pure opcode decode; gating by FSM state and busy-wait is done by the caller.
  function automatic decode_t decode_op(input logic [7:0] op);
    decode_t d;
    d = '{aluop: ALU_FWD, default: 1'b0};
    d.legal = 1'b1;
    case (op)
      OP_LOADI: begin d.imm_sel = 1'b1; d.reg_write = 1'b1; end
      OP_MOV:   begin d.reg_write = 1'b1; end
      OP_ADD:   begin d.aluop = ALU_ADD; d.reg_write = 1'b1; end
      OP_SUB:   begin d.aluop = ALU_ADD; d.neg_sel = 1'b1; d.reg_write = 1'b1; end
      OP_AND:   begin d.aluop = ALU_AND; d.reg_write = 1'b1; end
      OP_OR:    begin d.aluop = ALU_OR;  d.reg_write = 1'b1; end
      OP_ROR:   begin d.aluop = ALU_ROR; d.imm_sel = 1'b1; d.reg_write = 1'b1; end
      OP_J:     begin d.is_jump = 1'b1; end
      // Branches compare by subtracting: the ALU ZERO flag then means "equal".
      OP_BEQ:   begin d.aluop = ALU_ADD; d.neg_sel = 1'b1; d.is_beq = 1'b1; end
      OP_BNE:   begin d.aluop = ALU_ADD; d.neg_sel = 1'b1; d.is_bne = 1'b1; end
      OP_HALT:  begin d.is_halt = 1'b1; end
      default:  begin d.legal = 1'b0; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_control_pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program counter register with sequential (PC+4) and branch-target adders.
// Ports:
//   clk          system clock, rising edge
//   rst_b        synchronous active-low reset, loads RESET_PC
//   hold         keep PC unchanged this edge (stall, idle, halt)
//   take_branch  load branch target instead of PC+4
//   offset       signed branch offset in words
//   pc           current PC
// All arithmetic wraps modulo 2^PC_W.
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            hold,
  input  logic            take_branch,
  input  logic [7:0]      offset,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] offset_bytes;
  logic [PC_W-1:0] branch_target;

  assign pc_plus4      = pc_q + PC_W'(4);
  // Sign-extend the word offset, then scale to bytes.
  assign offset_bytes  = {{(PC_W-8){offset[7]}}, offset} << 2;
  assign branch_target = pc_plus4 + offset_bytes;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      pc_q <= RESET_PC;
    end else if (!hold) begin
      pc_q <= take_branch ? branch_target : pc_plus4;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_control.sv
// -----------------------------------------------------------------------------
// cpu_control
// Instruction-side control for the 8-bit CPU: owns the PC, decodes the
// instruction word, drives ALU SELECT / operand-mux controls and resolves
// beq/bne from the ALU ZERO flag.
//
// Ports:
//   CLK            system clock, rising edge
//   RESET          synchronous active-low reset
//   INSTRUCTION    instruction word {opcode, dest/offset, src1, src2/imm}
//   IMEM_BUSYWAIT  instruction memory stall; INSTRUCTION invalid while high
//   ZERO           ALU zero flag
//   PC             fetch address
//   ALUOP          ALU SELECT code
//   IMM_SEL        DATA2 from immediate
//   NEG_SEL        negate DATA2
//   IMMEDIATE      INSTRUCTION[7:0]
//   REG_WRITE      register-file write enable
//   WRITE_ADDR / READ1_ADDR / READ2_ADDR  register addresses
//   ILLEGAL        sticky undefined-opcode flag
//   RETIRED_COUNT / TAKEN_COUNT  saturating perf counters
//                  (only when CPU_CONTROL_PERF_EN is defined)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset release, PC holds, outputs deasserted
// EXEC  | decode INSTRUCTION, complete on first edge with no busy-wait
// HALT  | halt retired; PC frozen, outputs deasserted until reset
// -----------------------------------------------------------------------------
module cpu_control
  import cpu_ctrl_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [31:0]     INSTRUCTION,
  input  logic            IMEM_BUSYWAIT,
  input  logic            ZERO,
  output logic [PC_W-1:0] PC,
  output logic [2:0]      ALUOP,
  output logic            IMM_SEL,
  output logic            NEG_SEL,
  output logic [7:0]      IMMEDIATE,
  output logic            REG_WRITE,
  output logic [2:0]      WRITE_ADDR,
  output logic [2:0]      READ1_ADDR,
  output logic [2:0]      READ2_ADDR,
`ifdef CPU_CONTROL_PERF_EN
  output logic [15:0]     RETIRED_COUNT,
  output logic [15:0]     TAKEN_COUNT,
`endif
  output logic            ILLEGAL
);

  ctrl_state_e state;
  logic        illegal_q;
  decode_t     dec;
  logic        in_exec;
  logic        complete;
  logic        redirect;
  logic        pc_hold;
  logic        unused_instr_bits;

  assign dec      = decode_op(INSTRUCTION[31:24]);
  assign in_exec  = (state == ST_EXEC);
  assign complete = in_exec && !IMEM_BUSYWAIT;
  assign redirect = dec.is_jump || (dec.is_beq && ZERO) || (dec.is_bne && !ZERO);
  // halt retires without moving the PC.
  assign pc_hold  = !complete || dec.is_halt;

  // Source-1 upper bits are not register-address bits on this 8-register CPU.
  assign unused_instr_bits = ^INSTRUCTION[15:11];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_EXEC;
        ST_EXEC: begin
          if (!IMEM_BUSYWAIT) begin
            if (dec.is_halt) state <= ST_HALT;
            if (!dec.legal)  illegal_q <= 1'b1;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk         (CLK),
    .rst_b       (RESET),
    .hold        (pc_hold),
    .take_branch (redirect),
    .offset      (INSTRUCTION[23:16]),
    .pc          (PC)
  );

  // Control outputs are combinational from INSTRUCTION, gated by state.
  assign ALUOP      = in_exec ? dec.aluop : ALU_FWD;
  assign IMM_SEL    = in_exec && dec.imm_sel;
  assign NEG_SEL    = in_exec && dec.neg_sel;
  assign REG_WRITE  = complete && dec.reg_write;
  assign IMMEDIATE  = INSTRUCTION[7:0];
  assign WRITE_ADDR = INSTRUCTION[18:16];
  assign READ1_ADDR = INSTRUCTION[10:8];
  assign READ2_ADDR = INSTRUCTION[2:0];
  assign ILLEGAL    = illegal_q;

`ifdef CPU_CONTROL_PERF_EN
  logic [15:0] retired_q;
  logic [15:0] taken_q;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else if (complete) begin
      if (retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
      if (redirect && !dec.is_halt && taken_q != 16'hFFFF) taken_q <= taken_q + 16'd1;
    end
  end

  assign RETIRED_COUNT = retired_q;
  assign TAKEN_COUNT   = taken_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_cpu_control.sv
module tb_cpu_control;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        IMEM_BUSYWAIT;
  logic        ZERO;
  logic [31:0] PC;
  logic [2:0]  ALUOP;
  logic        IMM_SEL;
  logic        NEG_SEL;
  logic [7:0]  IMMEDIATE;
  logic        REG_WRITE;
  logic [2:0]  WRITE_ADDR;
  logic [2:0]  READ1_ADDR;
  logic [2:0]  READ2_ADDR;
  logic        ILLEGAL;
`ifdef CPU_CONTROL_PERF_EN
  logic [15:0] RETIRED_COUNT;
  logic [15:0] TAKEN_COUNT;
`endif

  cpu_control dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .INSTRUCTION   (INSTRUCTION),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .ZERO          (ZERO),
    .PC            (PC),
    .ALUOP         (ALUOP),
    .IMM_SEL       (IMM_SEL),
    .NEG_SEL       (NEG_SEL),
    .IMMEDIATE     (IMMEDIATE),
    .REG_WRITE     (REG_WRITE),
    .WRITE_ADDR    (WRITE_ADDR),
    .READ1_ADDR    (READ1_ADDR),
    .READ2_ADDR    (READ2_ADDR),
`ifdef CPU_CONTROL_PERF_EN
    .RETIRED_COUNT (RETIRED_COUNT),
    .TAKEN_COUNT   (TAKEN_COUNT),
`endif
    .ILLEGAL       (ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  // Reference model: instruction semantics as tables plus architectural state.
  logic [2:0]  m_alu   [256];
  bit          m_imm   [256];
  bit          m_neg   [256];
  bit          m_wr    [256];
  bit          m_legal [256];
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_halted;
  bit          m_illegal;
  logic [15:0] m_retired;
  logic [15:0] m_taken;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int op, input logic [2:0] alu, input bit imm, input bit neg, input bit wr);
    m_alu[op] = alu; m_imm[op] = imm; m_neg[op] = neg; m_wr[op] = wr; m_legal[op] = 1'b1;
  endtask

  task automatic do_reset(input logic [31:0] ins, input logic busy);
    @(negedge CLK);
    RESET = 1'b0; INSTRUCTION = ins; IMEM_BUSYWAIT = busy; ZERO = 1'b0;
    @(posedge CLK);
    m_pc = 32'd0; m_started = 0; m_halted = 0; m_illegal = 0;
    m_retired = 16'd0; m_taken = 16'd0;
    #1;
    chk("rst_pc", PC, 32'd0);
    chk("rst_illegal", 32'(ILLEGAL), 32'd0);
    chk("rst_reg_write", 32'(REG_WRITE), 32'd0);
  endtask

  // One clock: drive, check outputs against the model, then advance the model.
  task automatic cycle(input logic [31:0] ins, input logic busy, input logic zero);
    logic [7:0] op;
    bit         exec;
    bit         taken;
    int         soff;
    @(negedge CLK);
    RESET = 1'b1; INSTRUCTION = ins; IMEM_BUSYWAIT = busy; ZERO = zero;
    #1;
    op   = ins[31:24];
    exec = m_started && !m_halted;
    chk("pc", PC, m_pc);
    chk("aluop", 32'(ALUOP), exec ? 32'(m_alu[op]) : 32'd0);
    chk("imm_sel", 32'(IMM_SEL), 32'(exec && m_imm[op]));
    chk("neg_sel", 32'(NEG_SEL), 32'(exec && m_neg[op]));
    chk("reg_write", 32'(REG_WRITE), 32'(exec && !busy && m_wr[op]));
    chk("immediate", 32'(IMMEDIATE), 32'(ins[7:0]));
    chk("write_addr", 32'(WRITE_ADDR), 32'(ins[18:16]));
    chk("read1_addr", 32'(READ1_ADDR), 32'(ins[10:8]));
    chk("read2_addr", 32'(READ2_ADDR), 32'(ins[2:0]));
    chk("illegal", 32'(ILLEGAL), 32'(m_illegal));
    @(posedge CLK);
    if (!m_started) begin
      m_started = 1;
    end else if (exec && !busy) begin
      if (m_retired != 16'hFFFF) m_retired = m_retired + 16'd1;
      if (op == 8'hFF) begin
        m_halted = 1;
      end else begin
        taken = (op == 8'h06) || (op == 8'h07 && zero) || (op == 8'h08 && !zero);
        soff  = int'($signed(ins[23:16]));
        if (!m_legal[op]) m_illegal = 1;
        m_pc = m_pc + 32'd4 + (taken ? 32'(soff * 4) : 32'd0);
        if (taken && m_taken != 16'hFFFF) m_taken = m_taken + 16'd1;
      end
    end
  endtask

  task automatic pc_now(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, PC, exp);
  endtask

  initial begin
    logic [31:0] ins;
    logic [7:0]  rop;
    int          pick;

    RESET = 1'b0; INSTRUCTION = 32'd0; IMEM_BUSYWAIT = 1'b0; ZERO = 1'b0;
    for (int i = 0; i < 256; i++) begin
      m_alu[i] = 3'd0; m_imm[i] = 0; m_neg[i] = 0; m_wr[i] = 0; m_legal[i] = 0;
    end
    set_op(8'h00, 3'b000, 1, 0, 1);  // loadi
    set_op(8'h01, 3'b000, 0, 0, 1);  // mov
    set_op(8'h02, 3'b001, 0, 0, 1);  // add
    set_op(8'h03, 3'b001, 0, 1, 1);  // sub
    set_op(8'h04, 3'b010, 0, 0, 1);  // and
    set_op(8'h05, 3'b011, 0, 0, 1);  // or
    set_op(8'h06, 3'b000, 0, 0, 0);  // j
    set_op(8'h07, 3'b001, 0, 1, 0);  // beq
    set_op(8'h08, 3'b001, 0, 1, 0);  // bne
    set_op(8'h09, 3'b100, 1, 0, 1);  // ror
    set_op(8'hFF, 3'b000, 0, 0, 0);  // halt

    // Reset, IDLE cycle, then loadi completes.
    do_reset(32'h0002_0005, 1'b0);
    cycle(32'h0002_0005, 0, 0);
    cycle(32'h0002_0005, 0, 0);
    pc_now("loadi_next_pc", 32'd4);
    cycle(32'h0103_0102, 0, 0);
    pc_now("mov_next_pc", 32'd8);

    // Branches from PC=8 with offset -2 words.
    cycle(32'h07FE_0102, 0, 1);
    pc_now("beq_taken_pc", 32'd4);
    cycle(32'h0600_0000, 0, 0);
    cycle(32'h07FE_0102, 0, 0);
    pc_now("beq_not_taken_pc", 32'd12);
    cycle(32'h08FE_0102, 0, 0);
    pc_now("bne_taken_pc", 32'd8);
    cycle(32'h0600_0000, 0, 1);
    cycle(32'h08FE_0102, 0, 1);
    pc_now("bne_not_taken_pc", 32'd16);

    // Busy-wait on add for three cycles, then complete.
    for (int i = 0; i < 3; i++) cycle(32'h0201_0203, 1, $urandom_range(0, 1));
    pc_now("stall_pc_held", 32'd16);
    cycle(32'h0201_0203, 0, 0);
    pc_now("stall_done_pc", 32'd20);
    cycle(32'h0000_0000, 0, 0);

    // Randomised instruction stream (no halt).
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 20);
      rop  = (pick == 20) ? 8'h42 : 8'(pick % 10);
      ins  = {rop, 24'($urandom)};
      cycle(ins, ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
    end

    // Reset asserted mid-stall.
    cycle(32'h0201_0203, 1, 0);
    do_reset(32'h0201_0203, 1'b1);
    cycle(32'h0000_0000, 0, 0);

    // Illegal opcode, sticky flag, halt, frozen PC, reset clears.
    cycle(32'h4201_0203, 0, 0);
    pc_now("illegal_next_pc", 32'd4);
    chk("illegal_set", 32'(ILLEGAL), 32'd1);
    cycle(32'h0201_0203, 0, 0);
    cycle(32'hFF00_0000, 0, 0);
    for (int i = 0; i < 10; i++) cycle({8'($urandom_range(0, 9)), 24'($urandom)}, 0, $urandom_range(0, 1));
    pc_now("halt_frozen_pc", 32'd8);
    do_reset(32'h0000_0000, 1'b0);
    cycle(32'h0000_0000, 0, 0);

    // Wrap: jump back to 0xFFFFFFFC, then add wraps to 0.
    cycle(32'h06FE_0000, 0, 0);
    pc_now("jump_to_top_pc", 32'hFFFF_FFFC);
    cycle(32'h0201_0203, 0, 0);
    pc_now("wrap_pc", 32'd0);
    cycle(32'h0000_0000, 0, 0);

`ifdef CPU_CONTROL_PERF_EN
    do_reset(32'h0000_0000, 1'b0);
    cycle(32'h0000_0000, 0, 0);
    cycle(32'h0001_0007, 0, 0);
    cycle(32'h0600_0000, 0, 0);
    cycle(32'h0201_0203, 1, 0);
    cycle(32'h0201_0203, 0, 0);
    cycle(32'h0700_0102, 0, 1);
    cycle(32'h0503_0102, 0, 0);
    #1;
    chk("retired_count", 32'(RETIRED_COUNT), 32'd5);
    chk("taken_count", 32'(TAKEN_COUNT), 32'd2);
    chk("retired_model", 32'(RETIRED_COUNT), 32'(m_retired));
    chk("taken_model", 32'(TAKEN_COUNT), 32'(m_taken));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
